// File: rtl/vvp_pkg.sv
// Shared types and width helpers for the vvp sequencing controller.
package vvp_pkg;

  // Controller states
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StDrain = 2'b10,
    StDone  = 2'b11
  } vvp_state_e;

  // vvp operating mode encodings, passed through to the datapath unchanged
  typedef enum logic [1:0] {
    VvpMode00 = 2'b00,
    VvpMode01 = 2'b01,
    VvpMode10 = 2'b10,
    VvpMode11 = 2'b11
  } vvp_mode_e;

  // Width of the signed vvp partial sum S for an n-element vector
  function automatic int unsigned s_width(input int unsigned n);
    return $clog2(n) + 2;
  endfunction

  // Width of a weight plane index; never below one bit
  function automatic int unsigned plane_width(input int unsigned wpmax);
    return (wpmax > 1) ? $clog2(wpmax) : 1;
  endfunction

  // Width of a chunk index; never below one bit
  function automatic int unsigned chunk_width(input int unsigned chmax);
    return (chmax > 1) ? $clog2(chmax) : 1;
  endfunction

endpackage

// File: rtl/vvp_ctrl_tagpipe.sv
// Fixed-depth delay line for issue tags; wire-through when Depth is zero.
module vvp_ctrl_tagpipe #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] tag_i,
  output logic [Width-1:0] tag_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign tag_o = tag_i;
  end else begin : g_pipe
    logic [Width-1:0] stage_q [Depth];

    // Shift tags one stage per cycle; reset clears every stage valid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(Depth); i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= tag_i;
        for (int i = 1; i < int'(Depth); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign tag_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vvp_ctrl.sv
// Job sequencer for a bit-serial vector-vector product unit: issues operand
// fetches chunk by chunk and plane by plane, then accumulates the returned
// partial sums with per-plane weighting into a signed result.
module vvp_ctrl
  import vvp_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned PIPE  = 4,
  parameter int unsigned WPMAX = 8,
  parameter int unsigned CHMAX = 256,
  parameter int unsigned ACCW  = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              ready,
  input  logic [1:0]                        cfg_mode,
  input  logic [$clog2(WPMAX):0]            cfg_wprec,
  input  logic [$clog2(CHMAX):0]            cfg_nchunk,
  input  logic                              cfg_wsigned,
  output logic [1:0]                        vvp_mode,
  output logic                              rd_vld,
  output logic [chunk_width(CHMAX)-1:0]     rd_chunk,
  output logic [plane_width(WPMAX)-1:0]     rd_plane,
  input  logic signed [s_width(N)-1:0]      s_in,
  output logic signed [ACCW-1:0]            res,
  output logic                              res_vld,
  input  logic                              res_rdy
);

  localparam int unsigned SW  = s_width(N);
  localparam int unsigned PW  = plane_width(WPMAX);
  localparam int unsigned CW  = chunk_width(CHMAX);
  localparam int unsigned WPW = $clog2(WPMAX) + 1;
  localparam int unsigned CHW = $clog2(CHMAX) + 1;
  localparam int unsigned TW  = PW + 2;
  localparam int unsigned DW  = 4;

  vvp_state_e    state_q, state_d;
  vvp_mode_e     mode_q;
  logic [PW-1:0] last_plane_q, last_plane_d;
  logic [CW-1:0] last_chunk_q, last_chunk_d;
  logic          wsigned_q;
  logic [PW-1:0] plane_q, plane_d;
  logic [CW-1:0] chunk_q, chunk_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [ACCW-1:0] acc_q, acc_d;

  logic           cfg_load;
  logic           acc_clr;
  logic           issue;
  logic           last_issue;
  logic [WPW-1:0] wprec_eff;
  logic [CHW-1:0] nchunk_eff;
  logic [TW-1:0]  tag_in;
  logic [TW-1:0]  tag_out;
  logic           tag_vld;
  logic [PW-1:0]  tag_plane;
  logic           tag_neg;
  logic [ACCW-1:0] s_ext;
  logic [ACCW-1:0] addend;

  // Clamp requested plane and chunk counts into 1..max and keep the last index
  always_comb begin
    wprec_eff  = cfg_wprec;
    nchunk_eff = cfg_nchunk;
    if (cfg_wprec == '0) begin
      wprec_eff = WPW'(1);
    end else if (cfg_wprec > WPW'(WPMAX)) begin
      wprec_eff = WPW'(WPMAX);
    end
    if (cfg_nchunk == '0) begin
      nchunk_eff = CHW'(1);
    end else if (cfg_nchunk > CHW'(CHMAX)) begin
      nchunk_eff = CHW'(CHMAX);
    end
    last_plane_d = PW'(wprec_eff - WPW'(1));
    last_chunk_d = CW'(nchunk_eff - CHW'(1));
  end

  assign issue      = (state_q == StIssue);
  assign last_issue = issue && (plane_q == last_plane_q) && (chunk_q == last_chunk_q);

  // Sequencing FSM: issue loop counters, drain countdown and handshake
  always_comb begin
    state_d  = state_q;
    plane_d  = plane_q;
    chunk_d  = chunk_q;
    drain_d  = drain_q;
    cfg_load = 1'b0;
    acc_clr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cfg_load = 1'b1;
          acc_clr  = 1'b1;
          plane_d  = '0;
          chunk_d  = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (last_issue) begin
          plane_d = '0;
          chunk_d = '0;
          // With no pipeline the last sum lands this cycle, so drain is empty
          if (PIPE == 0) begin
            state_d = StDone;
          end else begin
            state_d = StDrain;
            drain_d = DW'(PIPE - 1);
          end
        end else if (plane_q == last_plane_q) begin
          plane_d = '0;
          chunk_d = chunk_q + CW'(1);
        end else begin
          plane_d = plane_q + PW'(1);
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      StDone: begin
        if (res_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Tag travels alongside the fetch so the returning S knows its plane weight
  assign tag_in = {issue, plane_q, wsigned_q & (plane_q == last_plane_q)};

  vvp_ctrl_tagpipe #(
    .Depth (PIPE),
    .Width (TW)
  ) u_tagpipe (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign tag_vld   = tag_out[TW-1];
  assign tag_plane = tag_out[TW-2:1];
  assign tag_neg   = tag_out[0];

  // Weighted accumulate, wrapping modulo 2^ACCW
  always_comb begin
    s_ext  = {{(ACCW - SW){s_in[SW-1]}}, s_in};
    addend = s_ext << tag_plane;
    acc_d  = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (tag_vld) begin
      acc_d = tag_neg ? (acc_q - addend) : (acc_q + addend);
    end
  end

  // State, counters, captured job configuration and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= VvpMode00;
      last_plane_q <= '0;
      last_chunk_q <= '0;
      wsigned_q    <= 1'b0;
      plane_q      <= '0;
      chunk_q      <= '0;
      drain_q      <= '0;
      acc_q        <= '0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      chunk_q <= chunk_d;
      drain_q <= drain_d;
      acc_q   <= acc_d;
      if (cfg_load) begin
        mode_q       <= vvp_mode_e'(cfg_mode);
        last_plane_q <= last_plane_d;
        last_chunk_q <= last_chunk_d;
        wsigned_q    <= cfg_wsigned;
      end
    end
  end

  // Outputs; fetch indices forced to zero outside the issue window
  always_comb begin
    ready    = (state_q == StIdle);
    rd_vld   = issue;
    rd_plane = issue ? plane_q : '0;
    rd_chunk = issue ? chunk_q : '0;
    vvp_mode = mode_q;
    res      = acc_q;
    res_vld  = (state_q == StDone);
  end

endmodule

// File: tb/tb_vvp_ctrl.sv
// Directed bench for vvp_ctrl: a PIPE=4 instance and a PIPE=0 instance share
// stimulus; a small vvp stand-in returns S values keyed on (chunk, plane).
module tb_vvp_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_wprec = '0;
  logic [8:0] cfg_nchunk = '0;
  logic       cfg_wsigned = 1'b0;
  logic       res_rdy = 1'b0;

  logic              ready, rd_vld, res_vld;
  logic [1:0]        vvp_mode;
  logic [7:0]        rd_chunk;
  logic [2:0]        rd_plane;
  logic signed [7:0] s_in;
  logic signed [31:0] res;

  logic              z_ready, z_rd_vld, z_res_vld;
  logic [1:0]        z_vvp_mode;
  logic [7:0]        z_rd_chunk;
  logic [2:0]        z_rd_plane;
  logic signed [7:0] z_s_in;
  logic signed [31:0] z_res;

  int                s_sel = 0;
  logic signed [7:0] s_const = '0;
  int                n_checks = 0;
  int                n_errors = 0;

  vvp_ctrl #(.N(64), .PIPE(4), .WPMAX(8), .CHMAX(256), .ACCW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .cfg_mode(cfg_mode),
    .cfg_wprec(cfg_wprec), .cfg_nchunk(cfg_nchunk), .cfg_wsigned(cfg_wsigned),
    .vvp_mode(vvp_mode), .rd_vld(rd_vld), .rd_chunk(rd_chunk), .rd_plane(rd_plane),
    .s_in(s_in), .res(res), .res_vld(res_vld), .res_rdy(res_rdy)
  );

  vvp_ctrl #(.N(64), .PIPE(0), .WPMAX(8), .CHMAX(256), .ACCW(32)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(z_ready), .cfg_mode(cfg_mode),
    .cfg_wprec(cfg_wprec), .cfg_nchunk(cfg_nchunk), .cfg_wsigned(cfg_wsigned),
    .vvp_mode(z_vvp_mode), .rd_vld(z_rd_vld), .rd_chunk(z_rd_chunk),
    .rd_plane(z_rd_plane), .s_in(z_s_in), .res(z_res), .res_vld(z_res_vld),
    .res_rdy(res_rdy)
  );

  // S value the stand-in vvp returns for a given fetch
  function automatic logic signed [7:0] sfun(input int sel, input logic signed [7:0] k,
                                             input logic [7:0] c, input logic [2:0] p);
    if (sel != 0) return 8'(10 * int'(c) + int'(p) + 1);
    return k;
  endfunction

  // Four-cycle fetch history for the PIPE=4 instance
  logic       h_vld [4];
  logic [7:0] h_c   [4];
  logic [2:0] h_p   [4];
  always @(posedge clk) begin
    h_vld[0] <= rd_vld;
    h_c[0]   <= rd_chunk;
    h_p[0]   <= rd_plane;
    for (int i = 1; i < 4; i++) begin
      h_vld[i] <= h_vld[i-1];
      h_c[i]   <= h_c[i-1];
      h_p[i]   <= h_p[i-1];
    end
  end

  always_comb s_in   = h_vld[3] ? sfun(s_sel, s_const, h_c[3], h_p[3]) : 8'sd0;
  always_comb z_s_in = z_rd_vld ? sfun(s_sel, s_const, z_rd_chunk, z_rd_plane) : 8'sd0;

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input string name, input logic [1:0] mode, input logic [3:0] wprec,
                         input logic [8:0] nchunk, input logic ws, input int sel,
                         input logic signed [7:0] sk, input int exp_wp, input int exp_nc,
                         input longint exp_res, input int hold);
    int t, cyc, nis, bad, ec, ep, zcyc, stall;
    s_sel       = sel;
    s_const     = sk;
    cfg_mode    = mode;
    cfg_wprec   = wprec;
    cfg_nchunk  = nchunk;
    cfg_wsigned = ws;
    start       = 1'b1;
    step();
    start       = 1'b0;
    cfg_mode    = ~mode;
    cfg_wprec   = 4'd5;
    cfg_nchunk  = 9'd7;
    cfg_wsigned = ~ws;
    t = exp_wp * exp_nc;
    cyc = 1; nis = 0; bad = 0; ec = 0; ep = 0; zcyc = -1;
    while (res_vld !== 1'b1 && cyc < 600) begin
      if (z_res_vld === 1'b1 && zcyc < 0) zcyc = cyc;
      if (ready !== 1'b0 || z_ready !== 1'b0) bad++;
      if (rd_vld === 1'b1) begin
        if (int'(rd_chunk) != ec || int'(rd_plane) != ep || cyc != nis + 1) bad++;
        nis++;
        if (ep == exp_wp - 1) begin
          ep = 0;
          ec++;
        end else begin
          ep++;
        end
      end else if (rd_chunk != '0 || rd_plane != '0) begin
        bad++;
      end
      step();
      cyc++;
    end
    check_eq({name, " issues"}, nis, t);
    check_eq({name, " issue order"}, bad, 0);
    check_eq({name, " res_vld cycle"}, cyc, t + 5);
    check_eq({name, " res"}, res, exp_res);
    check_eq({name, " vvp_mode"}, vvp_mode, mode);
    check_eq({name, " pipe0 res_vld cycle"}, zcyc, t + 1);
    check_eq({name, " pipe0 res"}, z_res, exp_res);
    stall = 0;
    for (int i = 0; i < hold; i++) begin
      start      = 1'b1;
      cfg_mode   = 2'(i);
      cfg_wprec  = 4'(i);
      cfg_nchunk = 9'(i + 3);
      if (res !== 32'(exp_res) || res_vld !== 1'b1 || ready !== 1'b0 || rd_vld !== 1'b0
          || z_res !== 32'(exp_res) || z_res_vld !== 1'b1 || vvp_mode !== mode) stall++;
      step();
    end
    start = 1'b0;
    if (hold > 0) check_eq({name, " held in done"}, stall, 0);
    res_rdy = 1'b1;
    step();
    res_rdy = 1'b0;
    check_eq({name, " ready after consume"}, {ready, z_ready, res_vld, z_res_vld}, 4'b1100);
  endtask

  initial begin
    repeat (3) step();
    check_eq("reset outputs", {ready, rd_vld, res_vld, vvp_mode, rd_chunk, rd_plane},
             {1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 3'd0});
    check_eq("reset res", res, 0);
    rst_n = 1'b1;
    step();
    check_eq("idle after reset", {ready, z_ready, rd_vld, res_vld}, 4'b1100);

    run_job("v1",     2'b01, 4'd1,  9'd1,   1'b0, 0,  8'sd64, 1, 1,   64,   2);
    run_job("v2",     2'b01, 4'd2,  9'd1,   1'b1, 0,  8'sd64, 2, 1,   -64,  0);
    run_job("v3",     2'b10, 4'd2,  9'd3,   1'b0, 1,  8'sd0,  2, 3,   105,  10);
    run_job("v3s",    2'b10, 4'd2,  9'd3,   1'b1, 1,  8'sd0,  2, 3,   -39,  0);
    run_job("neg",    2'b11, 4'd3,  9'd1,   1'b1, 0,  -8'sd5, 3, 1,   5,    0);
    run_job("v6",     2'b00, 4'd0,  9'd0,   1'b1, 0,  8'sd7,  1, 1,   -7,   0);
    run_job("wclamp", 2'b01, 4'd15, 9'd2,   1'b0, 1,  8'sd0,  8, 2,   6136, 0);
    run_job("cclamp", 2'b01, 4'd1,  9'd300, 1'b0, 0,  8'sd3,  1, 256, 768,  0);

    // Reset in cycle 3 of a six-issue job, then start again right away
    s_sel = 0; s_const = 8'sd50;
    cfg_mode = 2'b01; cfg_wprec = 4'd2; cfg_nchunk = 9'd3; cfg_wsigned = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_eq("midjob reset outputs",
             {ready, rd_vld, res_vld, vvp_mode, rd_chunk, rd_plane, z_rd_vld, z_res_vld},
             {1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 3'd0, 1'b0, 1'b0});
    check_eq("midjob reset res", res, 0);
    step();
    rst_n = 1'b1;
    run_job("post_rst", 2'b01, 4'd2, 9'd2, 1'b0, 0, 8'sd20, 2, 2, 120, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vvp_ctrl.md
VVP_CTRL -- requirements
Module: vvp_ctrl

Interface
REQ-001 Parameter: N, 64, vector width of the controlled vvp.
REQ-002 Parameter: PIPE, 4, cycles from rd_vld to the matching valid S at s_in (operand read latency plus vvp pipeline latency); legal range 0..15.
REQ-003 Parameter: WPMAX, 8, maximum weight bit-planes.
REQ-004 Parameter: CHMAX, 256, maximum chunks of N elements per job.
REQ-005 Parameter: ACCW, 32, accumulator and result width.
REQ-006 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-007 Port: rst_n, input, 1, reset, asynchronous and active-low.
REQ-008 Port: start, input, 1, job request.
REQ-009 Port: ready, output, 1, high in IDLE only.
REQ-010 Port: cfg_mode, input, 2, vvp mode, captured at start acceptance.
REQ-011 Port: cfg_wprec, input, clog2(WPMAX)+1, number of weight planes.
REQ-012 Port: cfg_nchunk, input, clog2(CHMAX)+1, number of chunks.
REQ-013 Port: cfg_wsigned, input, 1, MSB weight plane has negative weight.
REQ-014 Port: vvp_mode, output, 2, held captured mode.
REQ-015 Port: rd_vld, output, 1, operand fetch strobe.
REQ-016 Port: rd_chunk, output, clog2(CHMAX), chunk index of the fetch.
REQ-017 Port: rd_plane, output, clog2(WPMAX), weight plane index of the fetch.
REQ-018 Port: s_in, input, clog2(N)+2 signed, vvp S output.
REQ-019 Port: res, output, ACCW signed, dot-product result.
REQ-020 Port: res_vld, output, 1, result valid.
REQ-021 Port: res_rdy, input, 1, result consumer ready.

Function
REQ-022 States: IDLE, ISSUE, DRAIN, DONE.
REQ-023 IDLE: start=1 captures cfg_*, clears the accumulator, and moves to ISSUE; acceptance cycle = cycle 0.
REQ-024 cfg_wprec=0 is treated as 1; values above WPMAX are clamped to WPMAX; cfg_nchunk=0 is treated as 1; values above CHMAX are clamped to CHMAX.
REQ-025 ISSUE: rd_vld=1 in every cycle for T = nchunk*wprec consecutive cycles, starting at cycle 1.
REQ-026 Issue order: chunk outer loop from 0 upward; plane inner loop from 0 upward (LSB first).
REQ-027 After the last issue (chunk=nchunk-1, plane=wprec-1), the FSM moves to DRAIN.
REQ-028 Each issue pushes the tag {vld, plane, neg} into a PIPE-deep shift register; neg = wsigned AND (plane == wprec-1).
REQ-029 When a tag emerges with vld=1: acc <= acc + (sext(s_in) << plane) if neg=0, and acc - (sext(s_in) << plane) if neg=1.
REQ-030 PIPE=0 uses s_in in the same cycle as the issue.
REQ-031 Accumulation is two's-complement modulo 2^ACCW; no saturation and no overflow flag.
REQ-032 DRAIN: the FSM moves to DONE in the cycle after the last tag has been accumulated.
REQ-033 res_vld=1 from cycle T+PIPE+1 onward; res equals acc.
REQ-034 DONE: res and res_vld are held stable until res_rdy=1; on that edge the FSM moves to IDLE.
REQ-035 start outside IDLE is ignored; cfg_* changes outside IDLE have no effect.
REQ-036 rd_chunk and rd_plane are 0 whenever rd_vld=0.
REQ-037 vvp_mode always equals the captured mode.
REQ-038 res_vld and res_rdy both high in DONE: the result is consumed, and ready rises in the next cycle.
REQ-039 Back-to-back jobs: a new start can be accepted no earlier than 1 cycle after consumption.

Reset
REQ-040 rst_n low, at any time including mid-job, immediately forces: state=IDLE, ready=1, rd_vld=0, rd_chunk=0, rd_plane=0, all tag valids=0, acc=0, res=0, res_vld=0, vvp_mode=0, all captured config registers=0.
REQ-041 After rst_n deasserts, the first start is accepted on the first rising edge with start=1.

Structure
REQ-042 A shared package vvp_pkg holds the state enum, the mode encodings (00,01,10,11), and width helper functions for the S, plane and chunk widths.
REQ-043 One sub-module, vvp_ctrl_tagpipe, implements the parameterised PIPE-deep tag delay line, with a bypass when PIPE=0.

Verification
REQ-044 V1: N=64, PIPE=4, mode=01, wprec=1, nchunk=1, wsigned=0, all W=1, all D=+1 -> one rd_vld pulse at cycle 1; res_vld at cycle 6; res=64.
REQ-045 V2: wprec=2, wsigned=1, both planes all 1 (weights=-1), D=+1, mode=01 -> res=64+(64<<1 negated)=-64.
REQ-046 V3: nchunk=3, wprec=2 -> rd sequence (c,p) = (0,0),(0,1),(1,0),(1,1),(2,0),(2,1) in cycles 1..6; res_vld at cycle 11.
REQ-047 V4: hold res_rdy=0 for 10 cycles in DONE, pulse start and change cfg -> res stable, ready=0, no rd_vld; res_rdy=1 -> ready=1 next cycle.
REQ-048 V5: rst_n low at cycle 3 of a 6-issue job -> rd_vld=0 and res_vld=0 immediately; a later job produces the correct result with no stale tag contributions.
REQ-049 V6: cfg_wprec=0, cfg_nchunk=0 -> exactly one issue; PIPE=0 build gives res_vld at cycle 2.
